// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory (one combinational read port, one synchronous write port)
// between the instruction-fetch requester (reads only) and the data requester
// (loads and stores). Requests go through a two-stage registered pipeline:
// the accepted request is captured into the issue register, the issue
// register drives the memory ports in the next cycle, and the result appears
// one cycle later on the matching response port. Handshake-to-response
// latency is two cycles, at one acceptance per cycle.
//
// Arbitration favours the data side. A starvation counter counts the
// consecutive cycles in which fetch was requesting but not granted. When it
// reaches STARVE_LIMIT, fetch wins the next tie.
//
// A DRAIN state stops new acceptances so the pipeline can empty before a
// flush. drained reports that no access is left in flight.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   if_req_*                   fetch request (valid/addr) and ready
//   if_resp_*                  fetch response pulse and read data
//   d_req_*                    data request (valid/we/addr/wdata) and ready
//   d_resp_*                   load data or store ack pulse, with data
//   mem_read_* / mem_write_*   memory read and write ports
//   drain_req, drained         quiesce request and pipeline-empty status
//   err_oob                    pulse: the access now issuing is out of range
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_SIZE     = 1024,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   // fetch requester
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_req_addr,
   output logic                  if_req_ready,
   output logic                  if_resp_valid,
   output logic [DATA_WIDTH-1:0] if_resp_data,
   // data requester
   input  logic                  d_req_valid,
   input  logic                  d_req_we,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   output logic                  d_req_ready,
   output logic                  d_resp_valid,
   output logic [DATA_WIDTH-1:0] d_resp_data,
   // memory ports
   output logic                  mem_read_enable,
   output logic [ADDR_WIDTH-1:0] mem_read_addr,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_write_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   // control / status
   input  logic                  drain_req,
   output logic                  drained,
   output logic                  err_oob
);

   // The counter width must be at least 1, even when STARVE_LIMIT is 0.
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]      STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_SIZE);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic w_accept_en;
   logic w_grant_if;
   logic w_grant_d;
   logic w_grant_any;

   logic [CNT_W-1:0] r_starve_cnt;

   // issue stage
   logic                  r_iss_valid;
   logic                  r_iss_is_d;   // requester ID: 1 = data, 0 = fetch
   logic                  r_iss_we;
   logic [ADDR_WIDTH-1:0] r_iss_addr;
   logic [DATA_WIDTH-1:0] r_iss_wdata;
   logic                  w_iss_in_range;
   logic [DATA_WIDTH-1:0] w_rsp_data;

   // response stage
   logic                  r_if_rsp_valid;
   logic [DATA_WIDTH-1:0] r_if_rsp_data;
   logic                  r_d_rsp_valid;
   logic [DATA_WIDTH-1:0] r_d_rsp_data;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // NOTE: sequential state is updated with <= so that every flop samples
   // the values from before the edge, whatever order the blocks run in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // FSM: next-state logic
   // NOTE: assign a default first so that no path leaves w_state_nxt
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_RUN:   if (drain_req)  w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (!drain_req) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // FSM: outputs. Gating with reset keeps both readies at 0 while reset is
   // held, even when a requester is valid.
   always_comb begin
      w_accept_en = (r_state == ST_RUN) && reset;
      drained     = (r_state == ST_DRAIN) && !r_iss_valid &&
                    !r_if_rsp_valid && !r_d_rsp_valid;
   end

   // ------------------------------------------------------------------
   // Arbitration: data wins ties unless fetch has been starved for
   // STARVE_LIMIT consecutive cycles.
   // ------------------------------------------------------------------
   always_comb begin
      w_grant_d   = w_accept_en && d_req_valid &&
                    !(if_req_valid && (r_starve_cnt == STARVE_MAX));
      w_grant_if  = w_accept_en && if_req_valid && !w_grant_d;
      w_grant_any = w_grant_d || w_grant_if;
   end

   assign if_req_ready = w_grant_if;
   assign d_req_ready  = w_grant_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve_cnt <= '0;
      end else if (!if_req_valid || w_grant_if) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != STARVE_MAX) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Issue register: captures the winning request at the handshake edge.
   // The address and write data only change on a new acceptance, so the
   // memory address/data outputs hold their last value while idle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_iss_valid <= 1'b0;
         r_iss_is_d  <= 1'b0;
         r_iss_we    <= 1'b0;
         r_iss_addr  <= '0;
         r_iss_wdata <= '0;
      end else begin
         r_iss_valid <= w_grant_any;
         if (w_grant_any) begin
            r_iss_is_d <= w_grant_d;
            r_iss_we   <= w_grant_d && d_req_we;
            r_iss_addr <= w_grant_d ? d_req_addr : if_req_addr;
         end
         if (w_grant_d && d_req_we) r_iss_wdata <= d_req_wdata;
      end
   end

   // Memory ports are driven straight from the issue register. An
   // out-of-range access drives no enable and returns zero data.
   always_comb begin
      w_iss_in_range   = (r_iss_addr < ADDR_LIMIT);
      mem_read_enable  = r_iss_valid && !r_iss_we && w_iss_in_range;
      mem_write_enable = r_iss_valid &&  r_iss_we && w_iss_in_range;
      err_oob          = r_iss_valid && !w_iss_in_range;
      w_rsp_data       = mem_read_enable ? mem_read_data : '0;
   end

   assign mem_read_addr  = r_iss_addr;
   assign mem_write_addr = r_iss_addr;
   assign mem_write_data = r_iss_wdata;

   // ------------------------------------------------------------------
   // Response registers: routed by the recorded requester ID. Stores
   // return an acknowledge with zero data.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_rsp_valid <= 1'b0;
         r_if_rsp_data  <= '0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rsp_data   <= '0;
      end else begin
         r_if_rsp_valid <= r_iss_valid && !r_iss_is_d;
         r_d_rsp_valid  <= r_iss_valid &&  r_iss_is_d;
         if (r_iss_valid && !r_iss_is_d) r_if_rsp_data <= w_rsp_data;
         if (r_iss_valid &&  r_iss_is_d) r_d_rsp_data  <= w_rsp_data;
      end
   end

   assign if_resp_valid = r_if_rsp_valid;
   assign if_resp_data  = r_if_rsp_data;
   assign d_resp_valid  = r_d_rsp_valid;
   assign d_resp_data   = r_d_rsp_data;

endmodule
